ahb_lite_buffer_slave: RTL and testbench
========================================

Name: ahb_lite_buffer_slave

Overview:
- Parametrised AHB-Lite slave bridging a bus master to a USB endpoint data path through two byte FIFOs.
  - TX FIFO: filled by the bus, drained by the device.
  - RX FIFO: filled by the device, drained by the bus.
- Successor to the fixed-size endpoint buffer front end: adds configurable width/depth, multi-byte transfers sized by hsize, sticky error register and flush control.
- Sits between the AHB-Lite bus model/SoC fabric and the USB TX/RX encoder/decoder.

Parameters:
- ADDR_WIDTH, 4, haddr width in bits; register map uses bits [3:0].
- DATA_WIDTH, 32, hwdata/hrdata width; fixed at 32 (4 byte lanes).
- DEPTH, 64, bytes per FIFO; power of 2, range 4..128.
- CNT_W, $clog2(DEPTH)+1, width of occupancy counters.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- hsel  in  1  slave select
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- haddr  in  ADDR_WIDTH  byte address
- hsize  in  3  0=byte, 1=half, 2=word; others error
- hwrite  in  1  1=write
- hwdata  in  32  write data (data phase)
- hrdata  out  32  read data (data phase)
- hresp  out  1  error response
- hready  out  1  transfer complete
- rx_push  in  1  device writes rx_data into RX FIFO
- rx_data  in  8  device byte
- rx_full  out  1  RX FIFO full
- tx_pop  in  1  device consumes tx_data
- tx_data  out  8  TX FIFO head (combinational peek)
- tx_empty  out  1  TX FIFO empty

Behaviour:
- Reset: hrdata=0, hresp=0, hready=1, tx_data=0, tx_empty=1, rx_full=0, both FIFOs empty, CTRL=0, ERR=0.
- Transfer acceptance: address phase captured when hsel & htrans[1] & hready. BUSY/IDLE produce an OKAY zero-wait data phase with no side effect.
- Register map (word-aligned):
  - 0x0 STATUS, RO: [7:0] rx_count, [15:8] tx_count, [16] rx_full, [17] tx_empty.
  - 0x4 DATA: write pushes hsize bytes to TX, lane 0 first, little-endian; read pops hsize bytes from RX into lanes 0.. (unused lanes 0).
  - 0x8 CTRL, RW: bit0 flush_tx, bit1 flush_rx (both self-clear after one cycle); bit2 irq_en.
  - 0xC ERR, W1C: bit0 bus_err, bit1 rx_overflow.
- Errors:
  - Triggers: unmapped/unaligned address, write to STATUS, hsize>2, DATA write with free<bytes, DATA read with count<bytes.
  - Response: two-cycle ERROR (cycle 1: hresp=1, hready=0; cycle 2: hresp=1, hready=1).
  - No partial push/pop on error; ERR.bus_err set.
- Latency:
  - OKAY transfers are zero-wait.
  - Writes commit at the clock edge ending the data phase, so a back-to-back STATUS read sees the update.
  - A DATA read pops at the edge ending its data phase.
- Simultaneous events:
  - Device push and bus pop on RX in the same cycle both proceed; count is unchanged if single bytes.
  - Flush in the same cycle as a push/pop: flush wins, push dropped.
  - rx_push while full: byte dropped, ERR.rx_overflow set.
  - tx_pop while empty: ignored, tx_data holds 0.
- FIFO pointers: log2(DEPTH) bits with natural wrap; count saturates at DEPTH by construction.
- Reset mid-transfer: aborts the data phase and returns all state to reset values the next cycle.

Optional Feature:
- Macro: AHB_BUF_IRQ_EN.
- Defined: adds output port irq (1 bit, registered, reset 0), driven as irq = CTRL.irq_en & (rx_count!=0 | ERR!=0).
- Undefined: no irq port; CTRL bit2 remains RW storage with no effect.

Decomposition:
- Package ahb_buf_pkg holds:
  - htrans/hsize enums;
  - register offset constants (STATUS=0x0, DATA=0x4, CTRL=0x8, ERR=0xC);
  - ERR bit indices.
- Sub-module byte_fifo (params WIDTH=8, DEPTH), instantiated twice.
  - Ports: push of 1..4 bytes with a byte-count input, pop of 1..4 bytes, flush, count, combinational head-of-4 peek.

Test Plan:
- Reset → STATUS read returns 0x0002_0000; hresp=0.
- Word write 0x4433_2211 to 0x4 → tx_count=4; four tx_pop pulses yield 0x11, 0x22, 0x33, 0x44, then tx_empty=1.
- Device pushes 0xA1, 0xB2 → halfword read of 0x4 returns 0x0000_B2A1; a following word read errors (two-cycle hresp) and ERR reads 0x1.
- Fill RX with DEPTH=64 bytes then one more rx_push → rx_full=1, ERR.bit1=1; write 0x2 to ERR → ERR=0x1.
- Write to 0x0 and read from 0x6 → both give a two-cycle error; no state change other than ERR.bit0.
- TX holding 3 bytes, write CTRL=0x1 concurrent with tx_pop → next cycle tx_count=0, tx_empty=1, and CTRL bit0 reads 0.

Source files
------------

// File: rtl/ahb_lite_buffer_slave_pkg.sv
// Shared types and constants for the AHB-Lite endpoint buffer slave.
// Package ahb_buf_pkg: bus encodings, register offsets, ERR/CTRL bit positions.
package ahb_buf_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [1:0] {
        DP_IDLE,
        DP_ACTIVE,
        DP_ERR2
    } dp_state_e;

    localparam logic [3:0] REG_STATUS = 4'h0;
    localparam logic [3:0] REG_DATA   = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;
    localparam logic [3:0] REG_ERR    = 4'hC;

    localparam int unsigned ERR_BUS_BIT    = 0;
    localparam int unsigned ERR_RX_OVF_BIT = 1;

    localparam int unsigned CTRL_FLUSH_TX_BIT = 0;
    localparam int unsigned CTRL_FLUSH_RX_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT   = 2;

    // Byte count of a transfer; 0 marks an illegal hsize.
    function automatic logic [2:0] size_bytes(input logic [2:0] hsize);
        case (hsize)
            HSIZE_BYTE: size_bytes = 3'd1;
            HSIZE_HALF: size_bytes = 3'd2;
            HSIZE_WORD: size_bytes = 3'd4;
            default:    size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_buffer_slave_byte_fifo.sv
// Byte FIFO accepting/releasing 0..4 entries per cycle, with flush and a
// combinational peek of the four oldest entries (zero beyond occupancy).
module byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [2:0]                 push_n,
    input  logic [4*WIDTH-1:0]         push_data,
    input  logic [2:0]                 pop_n,
    output logic [$clog2(DEPTH):0]     count,
    output logic [4*WIDTH-1:0]         peek
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (3'(i) < push_n) begin
                    mem_d[wr_ptr_q + PTR_W'(i)] = push_data[i*WIDTH +: WIDTH];
                end
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
            count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    always_comb begin
        peek = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (CNT_W'(i) < count_q) begin
                peek[i*WIDTH +: WIDTH] = mem_q[rd_ptr_q + PTR_W'(i)];
            end
        end
        count = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ahb_lite_buffer_slave.sv
// AHB-Lite slave bridging the bus to USB endpoint TX/RX byte FIFOs.
// Optional macro AHB_BUF_IRQ_EN adds a registered irq output.
module ahb_lite_buffer_slave
    import ahb_buf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hsel,
    input  logic [1:0]            htrans,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [2:0]            hsize,
    input  logic                  hwrite,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hresp,
    output logic                  hready,
    input  logic                  rx_push,
    input  logic [7:0]            rx_data,
    output logic                  rx_full,
    input  logic                  tx_pop,
    output logic [7:0]            tx_data,
    output logic                  tx_empty
`ifdef AHB_BUF_IRQ_EN
    ,
    output logic                  irq
`endif
);
    dp_state_e   state_q, state_d;
    logic [3:0]  addr_q, addr_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;
    logic        irq_en_q, irq_en_d;
    logic [1:0]  err_q, err_d;

    logic [CNT_W-1:0] tx_count, rx_count, tx_free;
    logic [31:0]      tx_peek, rx_peek;
    logic [2:0]       nbytes, tx_push_n, tx_pop_n, rx_push_n, rx_pop_n;
    logic             accept, err_now, commit, flush_tx, flush_rx;
    logic [31:0]      lane_mask;
    logic             unused_tx_peek;

    byte_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .flush(flush_tx),
        .push_n(tx_push_n), .push_data(hwdata),
        .pop_n(tx_pop_n), .count(tx_count), .peek(tx_peek)
    );

    byte_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .flush(flush_rx),
        .push_n(rx_push_n), .push_data({24'd0, rx_data}),
        .pop_n(rx_pop_n), .count(rx_count), .peek(rx_peek)
    );

    always_comb begin
        tx_data        = tx_peek[7:0];
        unused_tx_peek = ^tx_peek[31:8];
        tx_empty       = (tx_count == '0);
        rx_full        = (rx_count == CNT_W'(DEPTH));
        tx_free        = CNT_W'(DEPTH) - tx_count;
        tx_pop_n       = (tx_pop && !tx_empty) ? 3'd1 : 3'd0;
        rx_push_n      = (rx_push && !rx_full) ? 3'd1 : 3'd0;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
        irq_en_d  = irq_en_q;
        err_d     = err_q;
        hready    = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        tx_push_n = 3'd0;
        rx_pop_n  = 3'd0;
        flush_tx  = 1'b0;
        flush_rx  = 1'b0;
        nbytes    = size_bytes(size_q);
        err_now   = 1'b0;
        commit    = 1'b0;

        case (nbytes)
            3'd1:    lane_mask = 32'h0000_00FF;
            3'd2:    lane_mask = 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase

        // Error checks use live occupancy so a preceding back-to-back commit is seen.
        if (state_q == DP_ACTIVE) begin
            err_now = (addr_q[1:0] != 2'b00) || (nbytes == 3'd0)
                   || (write_q && addr_q == REG_STATUS)
                   || (addr_q == REG_DATA && write_q && tx_free < CNT_W'(nbytes))
                   || (addr_q == REG_DATA && !write_q && rx_count < CNT_W'(nbytes));
            commit  = !err_now;
        end

        if (err_now) begin
            hready = 1'b0;
            hresp  = 1'b1;
            err_d[ERR_BUS_BIT] = 1'b1;
        end else if (state_q == DP_ERR2) begin
            hresp = 1'b1;
        end

        if (commit && write_q) begin
            case (addr_q)
                REG_DATA: tx_push_n = nbytes;
                REG_CTRL: begin
                    flush_tx = hwdata[CTRL_FLUSH_TX_BIT];
                    flush_rx = hwdata[CTRL_FLUSH_RX_BIT];
                    irq_en_d = hwdata[CTRL_IRQ_EN_BIT];
                end
                REG_ERR:  err_d = err_q & ~hwdata[1:0];
                default:  ;
            endcase
        end else if (commit) begin
            case (addr_q)
                REG_STATUS: hrdata = {14'd0, tx_empty, rx_full, 8'(tx_count), 8'(rx_count)};
                REG_DATA: begin
                    hrdata   = rx_peek & lane_mask;
                    rx_pop_n = nbytes;
                end
                REG_CTRL:   hrdata = {29'd0, irq_en_q, 2'b00};
                REG_ERR:    hrdata = {30'd0, err_q};
                default:    ;
            endcase
        end

        if (rx_push && rx_full) begin
            err_d[ERR_RX_OVF_BIT] = 1'b1;
        end

        accept = hsel && htrans[1] && hready;
        if (!hready) begin
            state_d = DP_ERR2;
        end else if (accept) begin
            state_d = DP_ACTIVE;
            addr_d  = haddr[3:0];
            write_d = hwrite;
            size_d  = hsize;
        end else begin
            state_d = DP_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DP_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            irq_en_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            irq_en_q <= irq_en_d;
            err_q    <= err_d;
        end
    end

`ifdef AHB_BUF_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_en_q && ((rx_count != '0) || (err_q != '0));
        irq   = irq_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_lite_buffer_slave.sv
// Directed self-checking bench for ahb_lite_buffer_slave (DEPTH = 64).
module tb_ahb_lite_buffer_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [1:0]  htrans;
    logic [3:0]  haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hresp;
    logic        hready;
    logic        rx_push;
    logic [7:0]  rx_data;
    logic        rx_full;
    logic        tx_pop;
    logic [7:0]  tx_data;
    logic        tx_empty;
`ifdef AHB_BUF_IRQ_EN
    logic        irq;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        dp_tx_pop = 1'b0;
    logic [31:0] rdata;

    ahb_lite_buffer_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .haddr(haddr),
        .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
        .hresp(hresp), .hready(hready), .rx_push(rx_push), .rx_data(rx_data),
        .rx_full(rx_full), .tx_pop(tx_pop), .tx_data(tx_data), .tx_empty(tx_empty)
`ifdef AHB_BUF_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One non-pipelined transfer; starts and ends 1 time unit after a rising edge.
    task automatic xfer(input string tag, input logic [3:0] addr, input logic wr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        input logic exp_err, output logic [31:0] rd);
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wdata; tx_pop = dp_tx_pop;
        @(negedge clk);
        rd = hrdata;
        check({tag, "_resp"}, {30'd0, hresp, hready}, exp_err ? 32'h2 : 32'h1);
        if (!hready) begin
            @(posedge clk); #1;
            tx_pop = 1'b0;
            @(negedge clk);
            check({tag, "_err2"}, {30'd0, hresp, hready}, 32'h3);
        end
        @(posedge clk); #1;
        tx_pop = 1'b0;
        dp_tx_pop = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [3:0] addr, input logic [2:0] size,
                      input logic [31:0] data, input logic exp_err);
        logic [31:0] dummy;
        xfer(tag, addr, 1'b1, size, data, exp_err, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [2:0] size,
                          input logic [31:0] exp, input logic exp_err);
        logic [31:0] got;
        xfer(tag, addr, 1'b0, size, 32'd0, exp_err, got);
        if (!exp_err) check(tag, got, exp);
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_push = 1'b1; rx_data = b;
        @(posedge clk); #1;
        rx_push = 1'b0;
    endtask

    task automatic pop_tx(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, tx_data}, {24'd0, exp});
        tx_pop = 1'b1;
        @(posedge clk); #1;
        tx_pop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hsize = 3'd2;
        hwrite = 1'b0; hwdata = '0; rx_push = 1'b0; rx_data = '0; tx_pop = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_outs", {hrdata[3:0], 2'b00, hresp, hready, tx_data, 7'd0, tx_empty, 7'd0, rx_full},
              {4'h0, 2'b00, 1'b0, 1'b1, 8'h00, 7'd0, 1'b1, 7'd0, 1'b0});
        rd_chk("rst_status", 4'h0, 3'd2, 32'h0002_0000, 1'b0);

        // Word write to TX, drained by the device lane 0 first.
        wr("tx_word", 4'h4, 3'd2, 32'h4433_2211, 1'b0);
        rd_chk("tx_cnt4", 4'h0, 3'd2, 32'h0000_0400, 1'b0);
        pop_tx("tx_b0", 8'h11);
        pop_tx("tx_b1", 8'h22);
        pop_tx("tx_b2", 8'h33);
        pop_tx("tx_b3", 8'h44);
        check("tx_empty", {31'd0, tx_empty}, 32'h1);
        pop_tx("tx_pop_empty", 8'h00);
        check("tx_empty_hold", {31'd0, tx_empty}, 32'h1);

        // RX halfword read, then an under-filled word read errors.
        push_rx(8'hA1);
        push_rx(8'hB2);
        rd_chk("rx_half", 4'h4, 3'd1, 32'h0000_B2A1, 1'b0);
        rd_chk("rx_word_under", 4'h4, 3'd2, 32'h0, 1'b1);
        rd_chk("err_bus", 4'hC, 3'd2, 32'h0000_0001, 1'b0);
        push_rx(8'hC3);
        rd_chk("rx_byte", 4'h4, 3'd0, 32'h0000_00C3, 1'b0);

        // Fill RX to DEPTH, overflow by one, W1C only the overflow bit.
        for (int i = 0; i < 64; i++) push_rx(8'(i));
        check("rx_full", {31'd0, rx_full}, 32'h1);
        push_rx(8'hFF);
        rd_chk("rx_full_status", 4'h0, 3'd2, 32'h0003_0040, 1'b0);
        rd_chk("err_ovf", 4'hC, 3'd2, 32'h0000_0003, 1'b0);
        wr("err_w1c_ovf", 4'hC, 3'd2, 32'h0000_0002, 1'b0);
        rd_chk("err_after_w1c", 4'hC, 3'd2, 32'h0000_0001, 1'b0);
        rd_chk("rx_first_word", 4'h4, 3'd2, 32'h0302_0100, 1'b0);
        wr("flush_rx", 4'h8, 3'd2, 32'h0000_0002, 1'b0);
        rd_chk("status_rx_flushed", 4'h0, 3'd2, 32'h0002_0000, 1'b0);

        // Illegal accesses: only ERR.bus_err may change.
        wr("err_clr", 4'hC, 3'd2, 32'h0000_0003, 1'b0);
        rd_chk("err_zero", 4'hC, 3'd2, 32'h0, 1'b0);
        wr("wr_status", 4'h0, 3'd2, 32'hFFFF_FFFF, 1'b1);
        rd_chk("rd_unaligned", 4'h6, 3'd2, 32'h0, 1'b1);
        wr("bad_hsize", 4'h4, 3'd3, 32'h1234_5678, 1'b1);
        rd_chk("err_after_bad", 4'hC, 3'd2, 32'h0000_0001, 1'b0);
        rd_chk("status_after_bad", 4'h0, 3'd2, 32'h0002_0000, 1'b0);

        // Fill TX completely; one more byte must error with no partial push.
        for (int i = 0; i < 16; i++) wr("tx_fill", 4'h4, 3'd2, 32'h1312_1110 + 32'(i) * 32'h0404_0404, 1'b0);
        rd_chk("tx_full_status", 4'h0, 3'd2, 32'h0000_4000, 1'b0);
        wr("tx_overfill", 4'h4, 3'd0, 32'h0000_00EE, 1'b1);
        rd_chk("tx_full_status2", 4'h0, 3'd2, 32'h0000_4000, 1'b0);
        check("tx_head_full", {24'd0, tx_data}, 32'h10);
        wr("flush_tx_full", 4'h8, 3'd2, 32'h0000_0001, 1'b0);
        rd_chk("status_tx_flushed", 4'h0, 3'd2, 32'h0002_0000, 1'b0);

        // Flush TX concurrent with a device pop: flush wins.
        wr("tx_word2", 4'h4, 3'd2, 32'h7766_5544, 1'b0);
        pop_tx("tx3_head", 8'h44);
        dp_tx_pop = 1'b1;
        wr("flush_tx_pop", 4'h8, 3'd2, 32'h0000_0001, 1'b0);
        check("flush_tx_empty", {23'd0, tx_empty, tx_data}, {23'd0, 1'b1, 8'h00});
        rd_chk("status_flush_pop", 4'h0, 3'd2, 32'h0002_0000, 1'b0);
        rd_chk("ctrl_selfclr", 4'h8, 3'd2, 32'h0, 1'b0);
        wr("ctrl_irq_en", 4'h8, 3'd2, 32'h0000_0004, 1'b0);
        rd_chk("ctrl_irq_rd", 4'h8, 3'd2, 32'h0000_0004, 1'b0);

        // Reset in the middle of a data phase.
        push_rx(8'h5A);
        hsel = 1'b1; htrans = 2'b10; haddr = 4'h4; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hDEAD_BEEF; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_bus", {30'd0, hresp, hready}, 32'h1);
        rd_chk("midrst_status", 4'h0, 3'd2, 32'h0002_0000, 1'b0);
        rd_chk("midrst_ctrl", 4'h8, 3'd2, 32'h0, 1'b0);
        rd_chk("midrst_err", 4'hC, 3'd2, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
